uart_led_sequencer: RTL and testbench
=====================================

# uart_led_sequencer

Command-driven LED controller between the UART receiver and the four board LEDs. It decodes one-byte commands into static, blinking or chasing 4-bit LED patterns, and times the animations with an internal prescaler. It returns a one-byte acknowledge to the UART transmitter through a start/busy handshake.

## Interface
Parameters:
- TICK_DIV, 12_500_000, clk cycles per animation tick (≥2; use 4 in simulation)
- ACK_EN, 1, 1 = send acknowledge bytes, 0 = TX_START never asserted

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- RX_DATA  in  8  received command byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid
- TX_BUSY  in  1  transmitter busy
- TX_DATA  out  8  acknowledge byte to transmitter
- TX_START  out  1  one-cycle transmit request
- LEDS_OUT  out  4  LED drive, registered
- MODE  out  2  00 static, 01 blink, 10 chase
- ERR_CNT  out  8  invalid-command count, saturating

## Operation
- Command byte: opcode = RX_DATA[7:4], PAT = RX_DATA[3:0]; decoded only when RX_VALID=1.
- 0x0N: MODE=static, LEDS_OUT=PAT.
- 0x1N: MODE=blink. LEDS_OUT alternates PAT / 0000 each tick and starts at PAT.
- 0x2N: MODE=chase. Load PAT; each tick rotate left by one, {r[2:0],r[3]}. PAT=0 stays 0.
- 0x3x: clear. MODE=static, LEDS_OUT=0000.
- Opcode 4..F: invalid. MODE and LEDS_OUT unchanged; ERR_CNT+1, saturating at 255.
- Ack byte: 0x41 ('A') for a valid command, 0x45 ('E') for an invalid one.
- Prescaler: counts 0..TICK_DIV-1; tick = one-cycle pulse at TICK_DIV-1, then wraps to 0. Any valid command (including invalid opcodes) resets the count to 0 and the blink phase to "on".
- Mode FSM states: S_STATIC, S_BLINK, S_CHASE. Transitions occur only on commands; ticks are ignored in S_STATIC.
- Ack FSM states: A_IDLE, A_PEND, A_SENT.
  - On a command, the ack slot loads the new byte and the state goes to A_PEND, from any state.
  - A_PEND with TX_BUSY=0: register TX_START=1 and TX_DATA=slot for one cycle, go to A_SENT.
  - A_SENT: one guard cycle (no TX_START), then A_IDLE.
- One ack slot only. A newer command overwrites a still-pending ack (latest wins), so earlier acks can be lost.
- ACK_EN=0: the ack FSM stays in A_IDLE.

## Timing
- Reset values: LEDS_OUT=0000, MODE=00, TX_START=0, TX_DATA=0x00, ERR_CNT=0, prescaler=0, blink phase=on, ack FSM=A_IDLE.
- RX_VALID sampled at edge n → LEDS_OUT, MODE and ERR_CNT updated at edge n (visible in cycle n+1).
- Earliest TX_START is high in cycle n+2, when TX_BUSY=0 during cycle n+1.
- TX_DATA holds its value after the TX_START pulse until the next pulse.
- Tick and command in the same cycle: the command wins and the tick is discarded.
- Consecutive commands back to back are all executed; only the last ack survives if TX is busy.
- TX_BUSY high indefinitely: the block stays in A_PEND; LED operation is unaffected.
- rst mid-operation (any state, any prescaler value): all outputs and state return to reset values at that edge; a pending ack is discarded.
- While rst=1, RX_VALID is ignored.

## Test plan
1. Reset, then RX 0x05 at cycle n → LEDS_OUT=0101 and MODE=00 at n+1; TX_START=1 with TX_DATA=0x41 in cycle n+2.
2. TICK_DIV=4, RX 0x13 → LEDS_OUT 0011 for 4 cycles, then 0000 for 4, then 0011; MODE=01.
3. TICK_DIV=4, RX 0x21 → LEDS_OUT 0001, 0010, 0100, 1000, 0001, stepping every 4 cycles.
4. RX 0x7F during chase → pattern continues rotating, phase restarted; ERR_CNT=1; ack 0x45. After 300 invalid bytes, ERR_CNT=255.
5. TX_BUSY=1, RX 0x01 then 0x9F → no TX_START while busy. Drop TX_BUSY → exactly one TX_START with TX_DATA=0x45, and LEDS_OUT=0001.
6. Blink active and ack pending, assert rst one cycle → LEDS_OUT=0000, MODE=00, ERR_CNT=0, no TX_START afterward.

Source files
------------

// File: rtl/uart_led_sequencer.sv
// ---------------------------------------------------------------------------
// uart_led_sequencer
//
// Turns one-byte commands from the UART receiver into 4-bit LED patterns.
// The patterns can be static, blinking or chasing. An internal prescaler
// times the animation. Each command is answered with an acknowledge byte,
// which is handed to the UART transmitter through a start/busy handshake.
//
// Command byte: opcode = RX_DATA[7:4], pattern = RX_DATA[3:0]
//   0x0N  static, LEDS_OUT = N
//   0x1N  blink,  LEDS_OUT alternates N / 0000 each tick, starting at N
//   0x2N  chase,  load N, then rotate left by one each tick
//   0x3x  clear,  static with LEDS_OUT = 0000
//   4..F  invalid: LEDs and mode are kept, ERR_CNT counts up (saturating)
//
// Handshake (TX side):
//   TX_START is a registered one-cycle request. It is raised only when the
//   ack slot is pending and TX_BUSY was low in the previous cycle. After each
//   request there is one guard cycle, so the transmitter has time to raise
//   TX_BUSY. TX_DATA is valid with TX_START and holds until the next request.
//   There is only one ack slot. A newer command overwrites a pending ack.
//
// Parameters:
//   TICK_DIV  clk cycles per animation tick (>= 2)
//   ACK_EN    1 = send acknowledge bytes, 0 = TX_START is never asserted
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   RX_DATA    received command byte
//   RX_VALID   one-cycle strobe qualifying RX_DATA
//   TX_BUSY    transmitter busy
//   TX_DATA    acknowledge byte to transmitter
//   TX_START   one-cycle transmit request
//   LEDS_OUT   registered LED drive
//   MODE       00 static, 01 blink, 10 chase (mirrors the mode FSM state)
//   ERR_CNT    saturating count of invalid opcodes
//   ack_state  debug view of the ack FSM (00 idle, 01 pending, 10 sent)
// ---------------------------------------------------------------------------
module uart_led_sequencer #(
    parameter int TICK_DIV = 12_500_000,
    parameter bit ACK_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    input  logic       TX_BUSY,
    output logic [7:0] TX_DATA,
    output logic       TX_START,
    output logic [3:0] LEDS_OUT,
    output logic [1:0] MODE,
    output logic [7:0] ERR_CNT,
    output logic [1:0] ack_state
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [7:0] ACK_OK  = 8'h41;  // 'A'
    localparam logic [7:0] ACK_ERR = 8'h45;  // 'E'

    typedef enum logic [1:0] {
        S_STATIC = 2'b00,
        S_BLINK  = 2'b01,
        S_CHASE  = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        A_IDLE = 2'b00,
        A_PEND = 2'b01,
        A_SENT = 2'b10
    } ack_t;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [3:0] opcode;
    logic [3:0] pat;
    logic       cmd;
    logic       op_valid;

    assign opcode   = RX_DATA[7:4];
    assign pat      = RX_DATA[3:0];
    assign cmd      = RX_VALID;
    assign op_valid = (opcode[3:2] == 2'b00);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mode_t          mode_q, mode_d;
    ack_t           ack_q, ack_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           phase_q, phase_d;   // blink phase, 1 = pattern shown
    logic [3:0]     pat_q, pat_d;       // blink pattern
    logic [3:0]     leds_q, leds_d;
    logic [7:0]     err_q, err_d;
    logic [7:0]     slot_q, slot_d;     // single ack slot
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic           tick;

    // A tick that coincides with a command is discarded. The command
    // restarts the prescaler, and the tick does not take effect.
    assign tick = (cnt_q == TICK_LAST) && !cmd;

    // ------------------------------------------------------------------
    // Mode FSM: only commands change the mode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= S_STATIC;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (cmd && op_valid) begin
            case (opcode[1:0])
                2'd0:    mode_d = S_STATIC;
                2'd1:    mode_d = S_BLINK;
                2'd2:    mode_d = S_CHASE;
                default: mode_d = S_STATIC;   // clear
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, LED pattern and error counter
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        pat_d   = pat_q;
        leds_d  = leds_q;
        err_d   = err_q;

        if (cmd) begin
            // Every command restarts the timing. An invalid opcode also
            // restarts the timing, but the LEDs keep their current pattern.
            cnt_d   = '0;
            phase_d = 1'b1;
            if (op_valid) begin
                case (opcode[1:0])
                    2'd0: leds_d = pat;
                    2'd1: begin
                        pat_d  = pat;
                        leds_d = pat;
                    end
                    2'd2:    leds_d = pat;
                    default: leds_d = 4'b0000;
                endcase
            end else if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end else begin
            if (cnt_q == TICK_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

            if (tick) begin
                case (mode_q)
                    S_BLINK: begin
                        phase_d = !phase_q;
                        leds_d  = phase_q ? 4'b0000 : pat_q;
                    end
                    S_CHASE: leds_d = {leds_q[2:0], leds_q[3]};
                    default: leds_d = leds_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
            pat_q   <= 4'b0000;
            leds_q  <= 4'b0000;
            err_q   <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pat_q   <= pat_d;
            leds_q  <= leds_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Ack FSM
    // A new command always reloads the slot and returns the FSM to A_PEND.
    // If a command arrives in the same cycle that a pending ack could be
    // sent, the command wins. The older ack is replaced before it is sent.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= A_IDLE;
        end else begin
            ack_q <= ack_d;
        end
    end

    always_comb begin
        ack_d      = ack_q;
        slot_d     = slot_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        if (ACK_EN) begin
            if (cmd) begin
                slot_d = op_valid ? ACK_OK : ACK_ERR;
                ack_d  = A_PEND;
            end else begin
                case (ack_q)
                    A_PEND: begin
                        if (!TX_BUSY) begin
                            tx_start_d = 1'b1;
                            tx_data_d  = slot_q;
                            ack_d      = A_SENT;
                        end
                    end
                    A_SENT:  ack_d = A_IDLE;   // guard cycle
                    default: ack_d = A_IDLE;
                endcase
            end
        end else begin
            ack_d = A_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= 8'h00;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            slot_q     <= slot_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign LEDS_OUT  = leds_q;
    assign MODE      = mode_q;
    assign ERR_CNT   = err_q;
    assign TX_START  = tx_start_q;
    assign TX_DATA   = tx_data_q;
    assign ack_state = ack_q;

endmodule

// File: tb/tb_uart_led_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for uart_led_sequencer with TICK_DIV = 4.
// A directed sequence drives commands. Acknowledge bytes the bench expects
// are pushed into exp_q. A monitor pops and compares one entry on every
// TX_START pulse.
// ---------------------------------------------------------------------------
module tb_uart_led_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       TX_BUSY;
    logic [7:0] TX_DATA;
    logic       TX_START;
    logic [3:0] LEDS_OUT;
    logic [1:0] MODE;
    logic [7:0] ERR_CNT;
    logic [1:0] ack_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    uart_led_sequencer #(
        .TICK_DIV(4),
        .ACK_EN  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .TX_BUSY  (TX_BUSY),
        .TX_DATA  (TX_DATA),
        .TX_START (TX_START),
        .LEDS_OUT (LEDS_OUT),
        .MODE     (MODE),
        .ERR_CNT  (ERR_CNT),
        .ack_state(ack_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle command. Return just after the sampling edge.
    task automatic send_cmd(input logic [7:0] b, input bit expect_ack, input logic [7:0] ack);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        if (expect_ack) exp_q.push_back(ack);
        step();
        RX_VALID = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (TX_START === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected_start", 8'd1, 8'd0);
            end else begin
                check("ack_data", TX_DATA, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        logic [3:0] exp_led;

        rst      = 1'b1;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        TX_BUSY  = 1'b0;
        repeat (3) step();

        // reset state
        check("rst_leds", {4'h0, LEDS_OUT}, 8'h00);
        check("rst_mode", {6'h0, MODE}, 8'h00);
        check("rst_txstart", {7'h0, TX_START}, 8'h00);
        check("rst_txdata", TX_DATA, 8'h00);
        check("rst_err", ERR_CNT, 8'h00);
        rst = 1'b0;
        step();

        // static 0x05 and ack latency
        send_cmd(8'h05, 1'b1, 8'h41);
        check("t1_leds", {4'h0, LEDS_OUT}, 8'h05);
        check("t1_mode", {6'h0, MODE}, 8'h00);
        check("t1_txstart_n1", {7'h0, TX_START}, 8'h00);
        step();
        check("t1_txstart_n2", {7'h0, TX_START}, 8'h01);
        check("t1_txdata_n2", TX_DATA, 8'h41);
        step();
        check("t1_txstart_n3", {7'h0, TX_START}, 8'h00);
        check("t1_txdata_hold", TX_DATA, 8'h41);
        repeat (3) step();

        // blink 0x13
        send_cmd(8'h13, 1'b1, 8'h41);
        check("t2_mode", {6'h0, MODE}, 8'h01);
        for (int c = 0; c < 12; c++) begin
            exp_led = (((c / 4) % 2) == 0) ? 4'b0011 : 4'b0000;
            check($sformatf("t2_blink_c%0d", c), {4'h0, LEDS_OUT}, {4'h0, exp_led});
            step();
        end

        // chase 0x21
        send_cmd(8'h21, 1'b1, 8'h41);
        check("t3_mode", {6'h0, MODE}, 8'h02);
        for (int c = 0; c < 20; c++) begin
            exp_led = 4'b0001 << ((c / 4) % 4);
            check($sformatf("t3_chase_c%0d", c), {4'h0, LEDS_OUT}, {4'h0, exp_led});
            step();
        end
        // Stop at the last cycle of a phase, so the command collides with a tick.
        repeat (3) step();
        check("t4_pre_leds", {4'h0, LEDS_OUT}, 8'h02);

        // invalid 0x7F during chase
        send_cmd(8'h7F, 1'b1, 8'h45);
        check("t4_err1", ERR_CNT, 8'h01);
        check("t4_mode", {6'h0, MODE}, 8'h02);
        for (int c = 0; c < 8; c++) begin
            exp_led = (c < 4) ? 4'b0010 : 4'b0100;
            check($sformatf("t4_chase_c%0d", c), {4'h0, LEDS_OUT}, {4'h0, exp_led});
            step();
        end

        // 300 invalid bytes back to back; only the last ack survives
        exp_q.push_back(8'h45);
        RX_VALID = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rb = {4'($urandom_range(4, 15)), 4'($urandom_range(0, 15))};
            RX_DATA = rb;
            step();
            if (i == 252) check("t4_err254", ERR_CNT, 8'd254);
            if (i == 253) check("t4_err255", ERR_CNT, 8'd255);
        end
        RX_VALID = 1'b0;
        check("t4_err_sat", ERR_CNT, 8'd255);
        repeat (5) step();

        // busy TX, two commands, latest ack wins
        TX_BUSY = 1'b1;
        send_cmd(8'h01, 1'b0, 8'h00);
        send_cmd(8'h9F, 1'b1, 8'h45);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("t5_no_start_c%0d", c), {7'h0, TX_START}, 8'h00);
            step();
        end
        check("t5_ack_pend", {6'h0, ack_state}, 8'h01);
        check("t5_leds_busy", {4'h0, LEDS_OUT}, 8'h01);
        TX_BUSY = 1'b0;
        step();
        check("t5_start", {7'h0, TX_START}, 8'h01);
        check("t5_data", TX_DATA, 8'h45);
        check("t5_leds", {4'h0, LEDS_OUT}, 8'h01);
        check("t5_mode", {6'h0, MODE}, 8'h00);
        repeat (4) step();

        // reset mid-blink with an ack pending
        TX_BUSY = 1'b1;
        send_cmd(8'h1A, 1'b0, 8'h00);
        repeat (2) step();
        check("t6_pre_leds", {4'h0, LEDS_OUT}, 8'h0A);
        rst      = 1'b1;
        RX_DATA  = 8'h0F;
        RX_VALID = 1'b1;     // must be ignored while in reset
        step();
        RX_VALID = 1'b0;
        rst      = 1'b0;
        TX_BUSY  = 1'b0;
        check("t6_leds", {4'h0, LEDS_OUT}, 8'h00);
        check("t6_mode", {6'h0, MODE}, 8'h00);
        check("t6_err", ERR_CNT, 8'h00);
        check("t6_txdata", TX_DATA, 8'h00);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("t6_no_start_c%0d", c), {7'h0, TX_START}, 8'h00);
            step();
        end
        check("t6_leds_after", {4'h0, LEDS_OUT}, 8'h00);

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
